// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, instruction field positions and controller state encoding shared by the issue controller.
// Latency: none (definitions only).
// Backpressure: not applicable. The optional debug read port is ALU_ISSUE_DBG_EN, handled in the users of this package.
package alu_pkg;

  // Opcodes the controller has to recognise
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Instruction field slice positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Branches and memory ops only report the alu result (a compare or an address).
  function automatic logic op_no_wb(input logic [5:0] opc);
    return (opc == OP_BEQ) || (opc == OP_BNE) || (opc == OP_LW) || (opc == OP_SW);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 32x32 register file, two async read ports, one sync write port (writeback has priority over preload).
// Latency: reads are combinational; writes land at the clock edge.
// Backpressure: none. ALU_ISSUE_DBG_EN adds a third combinational read port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter bit RF_RST_CLEAR = 1'b1,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ALU_ISSUE_DBG_EN
  input  logic [4:0]  i_dbg_raddr,
  output logic [31:0] o_dbg_rdata,
`endif
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic        i_pre_we,
  input  logic [4:0]  i_pre_addr,
  input  logic [31:0] i_pre_data
);

  logic [31:0] r_mem [32];
  logic        w_we;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;

  // Select the write source; the two never coincide, writeback wins if they ever did. r0 writes are dropped when hardwired.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (i_wb_we) begin
      w_we    = 1'b1;
      w_waddr = i_wb_addr;
      w_wdata = i_wb_data;
    end else if (i_pre_we) begin
      w_we    = 1'b1;
      w_waddr = i_pre_addr;
      w_wdata = i_pre_data;
    end
    if (R0_HARDWIRED && (w_waddr == 5'd0)) begin
      w_we = 1'b0;
    end
  end

  if (RF_RST_CLEAR) begin : g_rst_clear
    // Storage cleared by the async reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) begin
          r_mem[i] <= '0;
        end
      end else if (w_we) begin
        r_mem[w_waddr] <= w_wdata;
      end
    end
  end else begin : g_rst_keep
    // Storage keeps its contents across reset
    always_ff @(posedge clk) begin
      if (w_we) begin
        r_mem[w_waddr] <= w_wdata;
      end
    end
  end

  assign o_rdata_a = (R0_HARDWIRED && (i_raddr_a == 5'd0)) ? 32'd0 : r_mem[i_raddr_a];
  assign o_rdata_b = (R0_HARDWIRED && (i_raddr_b == 5'd0)) ? 32'd0 : r_mem[i_raddr_b];
`ifdef ALU_ISSUE_DBG_EN
  assign o_dbg_rdata = (R0_HARDWIRED && (i_dbg_raddr == 5'd0)) ? 32'd0 : r_mem[i_dbg_raddr];
`endif

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: reads rs/rt for one instruction, drives the combinational alu, captures and writes back its result.
// Latency: accept at edge T, alu inputs valid T..T+1, capture+writeback at T+1, done_valid from T+1; >=3 cycles per instr.
// Backpressure: instr_ready only in IDLE; done record held stable until done_ready. ALU_ISSUE_DBG_EN adds dbg_raddr/dbg_rdata.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter bit RF_RST_CLEAR = 1'b1,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ALU_ISSUE_DBG_EN
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
`endif
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_reg_a,
  output logic [31:0] alu_reg_b,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [31:0] done_result,
  output logic [2:0]  done_flags,
  output logic        done_wb,
  output logic [4:0]  done_waddr
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_done_result;
  logic [2:0]  r_done_flags;
  logic        r_done_wb;
  logic [4:0]  r_done_waddr;
  logic [31:0] w_rdata_a;
  logic [31:0] w_rdata_b;
  logic [5:0]  w_opc;
  logic [4:0]  w_dest;
  logic        w_wb_en;
  logic        w_accept;
  logic        w_in_issue;

  assign w_accept   = instr_valid && (r_state == ST_IDLE);
  assign w_in_issue = (r_state == ST_ISSUE);
  assign w_opc      = r_instr[OPC_HI:OPC_LO];
  assign w_dest     = (w_opc == OP_RTYPE) ? r_instr[RD_HI:RD_LO] : r_instr[RT_HI:RT_LO];
  assign w_wb_en    = !op_no_wb(w_opc) && !(R0_HARDWIRED && (w_dest == 5'd0));

  alu_regfile #(
    .RF_RST_CLEAR (RF_RST_CLEAR),
    .R0_HARDWIRED (R0_HARDWIRED)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ALU_ISSUE_DBG_EN
    .i_dbg_raddr (dbg_raddr),
    .o_dbg_rdata (dbg_rdata),
`endif
    .i_raddr_a   (r_instr[RS_HI:RS_LO]),
    .i_raddr_b   (r_instr[RT_HI:RT_LO]),
    .o_rdata_a   (w_rdata_a),
    .o_rdata_b   (w_rdata_b),
    .i_wb_we     (w_in_issue && w_wb_en),
    .i_wb_addr   (w_dest),
    .i_wb_data   (alu_result),
    .i_pre_we    (rf_we && (r_state == ST_IDLE)),
    .i_pre_addr  (rf_waddr),
    .i_pre_data  (rf_wdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: one issue cycle, then hold the record until it is taken
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_DONE;
      ST_DONE:  if (done_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: handshakes from state, alu operands only while issuing
  always_comb begin
    instr_ready     = (r_state == ST_IDLE);
    done_valid      = (r_state == ST_DONE);
    alu_instruction = '0;
    alu_reg_a       = '0;
    alu_reg_b       = '0;
    if (w_in_issue) begin
      alu_instruction = r_instr;
      alu_reg_a       = w_rdata_a;
      alu_reg_b       = w_rdata_b;
    end
  end

  // Instruction capture on accept, completion record capture at the end of the issue cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr       <= '0;
      r_done_result <= '0;
      r_done_flags  <= '0;
      r_done_wb     <= 1'b0;
      r_done_waddr  <= '0;
    end else begin
      if (w_accept) begin
        r_instr <= instr;
      end
      if (w_in_issue) begin
        r_done_result <= alu_result;
        r_done_flags  <= alu_flags;
        r_done_wb     <= w_wb_en;
        r_done_waddr  <= w_dest;
      end
    end
  end

  assign done_result = r_done_result;
  assign done_flags  = r_done_flags;
  assign done_wb     = r_done_wb;
  assign done_waddr  = r_done_waddr;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vector table, reset corner cases and random ops against a register-file reference model.
// Latency: the alu stand-in is combinational, as the real alu is.
// Backpressure: done_ready is held low for random stretches while another instruction is offered.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_instruction;
  logic [31:0] alu_reg_a;
  logic [31:0] alu_reg_b;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        done_valid;
  logic        done_ready;
  logic [31:0] done_result;
  logic [2:0]  done_flags;
  logic        done_wb;
  logic [4:0]  done_waddr;
`ifdef ALU_ISSUE_DBG_EN
  logic [4:0]  dbg_raddr = 5'd3;
  logic [31:0] dbg_rdata;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
`ifdef ALU_ISSUE_DBG_EN
    .dbg_raddr       (dbg_raddr),
    .dbg_rdata       (dbg_rdata),
`endif
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .alu_instruction (alu_instruction),
    .alu_reg_a       (alu_reg_a),
    .alu_reg_b       (alu_reg_b),
    .alu_result      (alu_result),
    .alu_flags       (alu_flags),
    .done_valid      (done_valid),
    .done_ready      (done_ready),
    .done_result     (done_result),
    .done_flags      (done_flags),
    .done_wb         (done_wb),
    .done_waddr      (done_waddr)
  );

  // Stand-in for the combinational alu: result plus flags {zero, negative, parity}
  function automatic logic [34:0] alu_fn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] imm;
    logic [31:0] r;
    imm = {{16{ins[15]}}, ins[15:0]};
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h22:   r = a - b;
          6'h24:   r = a & b;
          6'h25:   r = a | b;
          default: r = a + b;
        endcase
      end
      6'h04, 6'h05: r = a - b;
      6'h0c:        r = a & {16'h0, ins[15:0]};
      6'h0d:        r = a | {16'h0, ins[15:0]};
      default:      r = a + imm;
    endcase
    return {(r == 32'd0), r[31], ^r, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_instruction, alu_reg_a, alu_reg_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic [31:0] cap_ins, cap_a, cap_b, cap_res;
  logic [2:0]  cap_fl;
  logic        cap_wb;
  logic [4:0]  cap_wa;

  // Host preload of one register while idle
  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    rf_we = 1'b1; rf_waddr = addr; rf_wdata = data;
    @(posedge clk); #1;
    rf_we = 1'b0;
  endtask

  // Full handshake for one instruction; optional same-edge preload, stray rf_we while busy, done_ready stall
  task automatic exec(input logic [31:0] ins, input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input logic junk, input int hold);
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_ready", {31'd0, instr_ready}, 32'd1);
    instr = ins; instr_valid = 1'b1;
    rf_we = pwe; rf_waddr = pa; rf_wdata = pd;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rf_we = junk; rf_waddr = 5'($urandom); rf_wdata = $urandom;
    chk("issue_ready_low", {31'd0, instr_ready}, 32'd0);
    cap_ins = alu_instruction; cap_a = alu_reg_a; cap_b = alu_reg_b;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (done_valid !== 1'b1 && n < 20);
    chk("wait_done", {31'd0, done_valid}, 32'd1);
    chk("done_alu_zero", alu_instruction, 32'd0);
    cap_res = done_result; cap_fl = done_flags; cap_wb = done_wb; cap_wa = done_waddr;
    for (int i = 0; i < hold; i++) begin
      instr = $urandom; instr_valid = 1'b1;
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, done_valid}, 32'd1);
      chk("stall_ready", {31'd0, instr_ready}, 32'd0);
      chk("stall_result", done_result, cap_res);
      chk("stall_meta", {23'd0, done_flags, done_wb, done_waddr}, {23'd0, cap_fl, cap_wb, cap_wa});
      chk("stall_no_issue", alu_instruction, 32'd0);
    end
    instr_valid = 1'b0;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0; rf_we = 1'b0;
    chk("back_idle", {30'd0, instr_ready, done_valid}, 32'd2);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    int          hold;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] er;
    logic [2:0]  ef;
    logic        ewb;
    logic [4:0]  ewa;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] model[32];

  initial begin
    logic [5:0]  opc;
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] ins, ea, eb, er, pd;
    logic [2:0]  ef;
    logic [4:0]  pa;
    logic        pwe, ewb;
    logic [5:0]  opcs[8];
    logic [5:0]  functs[4];

    // add r3,r1,r2 / addi r4,r1,-1 / beq r1,r1 / add r0,r1,r2 / readback r3,r4 / r0 preload+read / same-edge r2 + stall / readback r5,r2
    tbl[0] = '{32'h00221820, 1'b0, 5'd0, 32'h0,        0, 32'h5,   32'h7,   32'hC,   3'b000, 1'b1, 5'd3};
    tbl[1] = '{32'h2024FFFF, 1'b0, 5'd0, 32'h0,        0, 32'h5,   32'h0,   32'h4,   3'b001, 1'b1, 5'd4};
    tbl[2] = '{32'h10210003, 1'b0, 5'd0, 32'h0,        0, 32'h5,   32'h5,   32'h0,   3'b100, 1'b0, 5'd0};
    tbl[3] = '{32'h00220020, 1'b0, 5'd0, 32'h0,        0, 32'h5,   32'h7,   32'hC,   3'b000, 1'b0, 5'd0};
    tbl[4] = '{32'h00640020, 1'b0, 5'd0, 32'h0,        0, 32'hC,   32'h4,   32'h10,  3'b001, 1'b0, 5'd0};
    tbl[5] = '{32'h00010020, 1'b1, 5'd0, 32'hDEADBEEF, 0, 32'h0,   32'h5,   32'h5,   3'b000, 1'b0, 5'd0};
    tbl[6] = '{32'h00222820, 1'b1, 5'd2, 32'h100,      5, 32'h5,   32'h100, 32'h105, 3'b001, 1'b1, 5'd5};
    tbl[7] = '{32'h00A20020, 1'b0, 5'd0, 32'h0,        0, 32'h105, 32'h100, 32'h205, 3'b001, 1'b0, 5'd0};

    opcs   = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h04, 6'h05, 6'h23, 6'h2b};
    functs = '{6'h20, 6'h22, 6'h24, 6'h25};

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0; done_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_payload", {23'd0, done_flags, done_wb, done_waddr}, 32'd0);
    chk("rst_result", done_result, 32'd0);
    chk("rst_alu", alu_instruction | alu_reg_a | alu_reg_b, 32'd0);

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    for (int i = 0; i < 8; i++) begin
      exec(tbl[i].ins, tbl[i].pwe, tbl[i].pa, tbl[i].pd, 1'b0, tbl[i].hold);
      chk($sformatf("v%0d_instr", i), cap_ins, tbl[i].ins);
      chk($sformatf("v%0d_reg_a", i), cap_a, tbl[i].ea);
      chk($sformatf("v%0d_reg_b", i), cap_b, tbl[i].eb);
      chk($sformatf("v%0d_result", i), cap_res, tbl[i].er);
      chk($sformatf("v%0d_flags", i), {29'd0, cap_fl}, {29'd0, tbl[i].ef});
      chk($sformatf("v%0d_wb", i), {31'd0, cap_wb}, {31'd0, tbl[i].ewb});
      if (tbl[i].ewb) chk($sformatf("v%0d_waddr", i), {27'd0, cap_wa}, {27'd0, tbl[i].ewa});
    end

    // Random ops checked against a plain array model of the register file
    for (int r = 0; r < 32; r++) begin
      pd = $urandom;
      preload(5'(r), pd);
      model[r] = (r == 0) ? 32'd0 : pd;
    end
    for (int k = 0; k < 200; k++) begin
      opc = opcs[$urandom_range(0, 7)];
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      if ($urandom_range(0, 7) == 0) rd = 5'd0;
      ins = (opc == 6'h00) ? {opc, rs, rt, rd, 5'd0, functs[$urandom_range(0, 3)]}
                           : {opc, rs, rt, 16'($urandom)};
      pwe = ($urandom_range(0, 3) == 0);
      pa = 5'($urandom); pd = $urandom;
      if (pwe && pa != 5'd0) model[pa] = pd;
      ea = model[rs]; eb = model[rt];
      {ef, er} = alu_fn(ins, ea, eb);
      dest = (opc == 6'h00) ? rd : rt;
      ewb = !(opc == 6'h04 || opc == 6'h05 || opc == 6'h23 || opc == 6'h2b) && (dest != 5'd0);
      exec(ins, pwe, pa, pd, 1'($urandom), $urandom_range(0, 2));
      if (ewb) model[dest] = er;
      chk("rnd_instr", cap_ins, ins);
      chk("rnd_reg_a", cap_a, ea);
      chk("rnd_reg_b", cap_b, eb);
      chk("rnd_result", cap_res, er);
      chk("rnd_flags_wb", {28'd0, cap_fl, cap_wb}, {28'd0, ef, ewb});
      if (ewb) chk("rnd_waddr", {27'd0, cap_wa}, {27'd0, dest});
    end

    // Reset during ISSUE: record dropped, no writeback
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    instr = 32'h00221820; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("midrst_issuing", alu_instruction, 32'h00221820);
    rst_n = 1'b0;
    #1;
    chk("midrst_done_valid", {31'd0, done_valid}, 32'd0);
    chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
    chk("midrst_alu_zero", alu_instruction, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ready", {31'd0, instr_ready}, 32'd1);
    chk("postrst_no_record", {31'd0, done_valid}, 32'd0);
    exec(32'h00640020, 1'b0, 5'd0, 32'd0, 1'b0, 0);
    chk("postrst_r3_unwritten", cap_a, 32'd0);
    chk("postrst_r4_cleared", cap_b, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
